// File: rtl/tile_grid_renderer.sv
// tile_grid_renderer
//   Rasterises a GRID_DIM x GRID_DIM board of tile exponents into a
//   SCREEN_W x SCREEN_H framebuffer, one pixel per accepted write, in
//   ascending address order. The board is snapshotted at frame start.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   board_flat    tile i at [i*VAL_W +: VAL_W], i = row*GRID_DIM+col
//   redraw_req    pulse requesting one frame (queued once while busy)
//   auto_refresh  restart after every frame while high
//   busy          frame in progress (SNAP/DRAW/DONE)
//   frame_done    one-cycle pulse after the last pixel is accepted
//   fb_we         write valid
//   fb_addr       y*SCREEN_W + x
//   fb_wdata      {colour[11:0], 20'd0}
//   fb_ready      write accepted when fb_we && fb_ready

`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module tile_grid_renderer #(
    parameter int          GRID_DIM   = 4,
    parameter int          VAL_W      = 4,
    parameter int          TILE_PX    = 56,
    parameter int          GAP_PX     = 4,
    parameter int          ORIGIN_X   = 40,
    parameter int          ORIGIN_Y   = 0,
    parameter int          SCREEN_W   = 320,
    parameter int          SCREEN_H   = 240,
    parameter logic [11:0] BG_COLOUR  = 12'h000,
    parameter logic [11:0] GAP_COLOUR = 12'hBA9
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [GRID_DIM*GRID_DIM*VAL_W-1:0] board_flat,
    input  logic                               redraw_req,
    input  logic                               auto_refresh,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               fb_we,
    output logic [`DISP_ADDR_WIDTH-1:0]        fb_addr,
    output logic [31:0]                        fb_wdata,
    input  logic                               fb_ready
);

    localparam int PITCH   = TILE_PX + GAP_PX;
    localparam int BOARD_W = GRID_DIM * GRID_DIM * VAL_W;
    localparam int ADDR_W  = `DISP_ADDR_WIDTH;
    localparam int X_W     = $clog2(SCREEN_W);
    localparam int Y_W     = $clog2(SCREEN_H);
    localparam int OFF_W   = $clog2(PITCH);
    localparam int TILE_W  = $clog2(GRID_DIM + 1);

    typedef enum logic [1:0] {S_IDLE, S_SNAP, S_DRAW, S_DONE} state_t;

    // Per-axis position inside the grid, tracked incrementally:
    // act  = coordinate lies within the grid extent (border gap included)
    // off  = offset inside the current pitch cell (gap first, then tile)
    // tile = pitch-cell index; GRID_DIM marks the trailing border gap
    typedef struct packed {
        logic              act;
        logic [OFF_W-1:0]  off;
        logic [TILE_W-1:0] tile;
    } axis_t;

    function automatic axis_t axis_restart(input logic at_origin);
        axis_t a;
        a.act  = at_origin;
        a.off  = '0;
        a.tile = '0;
        return a;
    endfunction

    function automatic axis_t axis_step(input axis_t a);
        axis_t n;
        n = a;
        if (a.act) begin
            if (a.off == OFF_W'(PITCH - 1)) begin
                n.off  = '0;
                n.tile = a.tile + TILE_W'(1);
            end else begin
                n.off = a.off + OFF_W'(1);
            end
            // Last pixel of the trailing border gap closes the extent.
            if (a.tile == TILE_W'(GRID_DIM) && a.off == OFF_W'(GAP_PX - 1))
                n.act = 1'b0;
        end
        return n;
    endfunction

    function automatic logic is_gap(input axis_t a);
        return (a.off < OFF_W'(GAP_PX)) || (a.tile == TILE_W'(GRID_DIM));
    endfunction

    function automatic logic [11:0] tile_lut(input logic [VAL_W-1:0] v);
        logic [11:0] c;
        case (32'(v))
            0:       c = 12'hEEE;
            1:       c = 12'hFFE;
            2:       c = 12'hFFC;
            3:       c = 12'hFC8;
            4:       c = 12'hF96;
            5:       c = 12'hF74;
            6:       c = 12'hF52;
            7:       c = 12'hF30;
            8:       c = 12'hEC2;
            9:       c = 12'hEC0;
            10:      c = 12'hEB0;
            default: c = 12'hE90;
        endcase
        return c;
    endfunction

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic                pend_q, pend_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    axis_t               ax_q, ax_d;
    axis_t               ay_q, ay_d;
    logic [BOARD_W-1:0]  snap_q, snap_d;
    logic [VAL_W-1:0]    tile_val;
    logic [11:0]         colour;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (redraw_req || pend_q || auto_refresh)
                    state_d = S_SNAP;
            end
            S_SNAP: begin
                snap_d  = board_flat;
                // A request landing in this very cycle still earns a frame.
                pend_d  = redraw_req;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
                ax_d    = axis_restart(ORIGIN_X == 0);
                ay_d    = axis_restart(ORIGIN_Y == 0);
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (redraw_req)
                    pend_d = 1'b1;
                if (fb_ready) begin
                    if (x_q == X_W'(SCREEN_W - 1) && y_q == Y_W'(SCREEN_H - 1)) begin
                        // Counters hold so the address never passes the last pixel.
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (x_q == X_W'(SCREEN_W - 1)) begin
                            x_d  = '0;
                            ax_d = axis_restart(ORIGIN_X == 0);
                            y_d  = y_q + Y_W'(1);
                            ay_d = (y_d == Y_W'(ORIGIN_Y)) ? axis_restart(1'b1)
                                                           : axis_step(ay_q);
                        end else begin
                            x_d  = x_q + X_W'(1);
                            ax_d = (x_d == X_W'(ORIGIN_X)) ? axis_restart(1'b1)
                                                           : axis_step(ax_q);
                        end
                    end
                end
            end
            default: begin
                if (redraw_req)
                    pend_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        we_d   = (state_d == S_DRAW);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            pend_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            pend_q  <= pend_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    // Pick the snapshot entry addressed by the current tile row/column.
    always_comb begin
        tile_val = '0;
        for (int r = 0; r < GRID_DIM; r++) begin
            for (int c = 0; c < GRID_DIM; c++) begin
                if (ay_q.tile == TILE_W'(r) && ax_q.tile == TILE_W'(c))
                    tile_val = snap_q[(r*GRID_DIM + c)*VAL_W +: VAL_W];
            end
        end
    end

    always_comb begin
        if (!(ax_q.act && ay_q.act))
            colour = BG_COLOUR;
        else if (is_gap(ax_q) || is_gap(ay_q))
            colour = GAP_COLOUR;
        else
            colour = tile_lut(tile_val);
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_wdata   = we_q ? {colour, 20'd0} : 32'd0;

endmodule

// File: tb/tb_tile_grid_renderer.sv
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module tb_tile_grid_renderer;

    localparam int G    = 4;
    localparam int VW   = 4;
    localparam int TP   = 6;
    localparam int GP   = 2;
    localparam int OX   = 5;
    localparam int OY   = 3;
    localparam int W    = 48;
    localparam int H    = 32;
    localparam int P    = TP + GP;
    localparam int EXT  = G * P + GP;
    localparam int NPIX = W * H;
    localparam int BW   = G * G * VW;
    localparam logic [11:0] BG  = 12'h000;
    localparam logic [11:0] GAPC = 12'hBA9;
    localparam logic [11:0] LUT [12] = '{12'hEEE, 12'hFFE, 12'hFFC, 12'hFC8, 12'hF96, 12'hF74,
                                         12'hF52, 12'hF30, 12'hEC2, 12'hEC0, 12'hEB0, 12'hE90};

    logic                         clk;
    logic                         reset;
    logic [BW-1:0]                board;
    logic                         redraw_req;
    logic                         auto_refresh;
    logic                         busy;
    logic                         frame_done;
    logic                         fb_we;
    logic [`DISP_ADDR_WIDTH-1:0]  fb_addr;
    logic [31:0]                  fb_wdata;
    logic                         fb_ready;

    tile_grid_renderer #(
        .GRID_DIM(G), .VAL_W(VW), .TILE_PX(TP), .GAP_PX(GP),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .SCREEN_W(W), .SCREEN_H(H),
        .BG_COLOUR(BG), .GAP_COLOUR(GAPC)
    ) dut (
        .clk(clk), .reset(reset), .board_flat(board), .redraw_req(redraw_req),
        .auto_refresh(auto_refresh), .busy(busy), .frame_done(frame_done),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            frames  = 0;
    int            px_cnt  = 0;
    int            done_cyc = 0;
    int            first_we_cyc = 0;
    logic          we_prev = 1'b0;
    logic          rdy_rand = 1'b0;
    logic [BW-1:0] cur_board = '0;
    logic [BW-1:0] exp_q [$];
    logic [11:0]   cap [NPIX];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference pixel colour from plain geometry: offset, pitch division, LUT.
    function automatic logic [11:0] model_colour(input int x, input int y, input logic [BW-1:0] b);
        int px, py, tx, ty, v;
        px = x - OX;
        py = y - OY;
        if (px < 0 || px >= EXT || py < 0 || py >= EXT) return BG;
        if ((px % P) < GP || (py % P) < GP || px >= G * P || py >= G * P) return GAPC;
        tx = (px - GP) / P;
        ty = (py - GP) / P;
        v  = int'(b[(ty * G + tx) * VW +: VW]);
        return LUT[(v > 11) ? 11 : v];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            fb_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard: every accepted write must be the next pixel of the frame.
    always @(negedge clk) begin
        if (reset) begin
            px_cnt  = 0;
            we_prev = 1'b0;
        end else begin
            if (fb_we && !we_prev) first_we_cyc = cyc;
            if (fb_we && fb_ready) begin
                if (px_cnt == 0) begin
                    if (exp_q.size() > 0) cur_board = exp_q.pop_front();
                    else chk("unexpected_frame", 1, 0);
                end
                chk("addr", 64'(fb_addr), 64'(px_cnt));
                chk("data", 64'(fb_wdata),
                    64'({model_colour(px_cnt % W, px_cnt / W, cur_board), 20'd0}));
                if (px_cnt < NPIX) cap[px_cnt] = fb_wdata[31:20];
                px_cnt++;
            end
            if (frame_done) begin
                chk("frame_len", 64'(px_cnt), 64'(NPIX));
                px_cnt   = 0;
                frames++;
                done_cyc = cyc;
            end
            we_prev = fb_we;
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int target;
        target = frames + n;
        for (int i = 0; i < budget && frames < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk("frame_wait", 64'(frames), 64'(target));
    endtask

    task automatic pulse_req();
        @(posedge clk); #2 redraw_req = 1'b1;
        @(posedge clk); #2 redraw_req = 1'b0;
    endtask

    function automatic logic [BW-1:0] rand_board();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int t, base, d1;
        logic [BW-1:0] b;

        reset = 1'b1; redraw_req = 1'b0; auto_refresh = 1'b0; board = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(frame_done), 0);
        chk("rst_we", 64'(fb_we), 0);
        chk("rst_addr", 64'(fb_addr), 0);
        chk("rst_wdata", 64'(fb_wdata), 0);
        @(posedge clk); #2 reset = 1'b0;

        // Single frame, fb_ready=1: latency and length.
        board = rand_board();
        exp_q.push_back(board);
        @(posedge clk); #2 redraw_req = 1'b1; t = cyc;
        @(negedge clk);
        chk("lat_busy_t", 64'(busy), 0);
        @(posedge clk); #2 redraw_req = 1'b0;
        @(negedge clk);
        chk("lat_busy_t1", 64'(busy), 1);
        chk("lat_we_t1", 64'(fb_we), 0);
        @(negedge clk);
        chk("lat_we_t2", 64'(fb_we), 1);
        wait_frames(1, NPIX + 20);
        chk("done_cycle", 64'(done_cyc), 64'(t + 2 + NPIX));
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 0);

        // Random board under random backpressure.
        rdy_rand = 1'b1;
        board = rand_board();
        exp_q.push_back(board);
        pulse_req();
        wait_frames(1, 4 * NPIX);

        // Fixed board with known pixel colours.
        b = '0;
        b[5 * VW +: VW]  = 4'd11;
        b[15 * VW +: VW] = 4'd3;
        board = b;
        exp_q.push_back(board);
        pulse_req();
        wait_frames(1, 4 * NPIX);
        chk("px_0_0_bg", 64'(cap[0 * W + 0]), 64'(12'h000));
        chk("px_5_3_gap", 64'(cap[3 * W + 5]), 64'(12'hBA9));
        chk("px_7_5_t0", 64'(cap[5 * W + 7]), 64'(12'hEEE));
        chk("px_13_5_gap", 64'(cap[5 * W + 13]), 64'(12'hBA9));
        chk("px_15_5_t1", 64'(cap[5 * W + 15]), 64'(12'hEEE));
        chk("px_15_13_t5", 64'(cap[13 * W + 15]), 64'(12'hE90));
        chk("px_31_29_t15", 64'(cap[29 * W + 31]), 64'(12'hFC8));
        chk("px_38_5_rgap", 64'(cap[5 * W + 38]), 64'(12'hBA9));
        chk("px_39_5_bg", 64'(cap[5 * W + 39]), 64'(12'h000));
        chk("px_7_31_clip", 64'(cap[31 * W + 7]), 64'(12'hEEE));

        // Three requests mid-frame with a board change: exactly one extra frame.
        base = frames;
        board = rand_board();
        exp_q.push_back(board);
        pulse_req();
        for (int i = 0; i < 4 * NPIX && px_cnt < 200; i++) @(negedge clk);
        chk("reach_px200", 64'(px_cnt >= 200), 1);
        board = rand_board();
        exp_q.push_back(board);
        for (int k = 0; k < 3; k++) begin
            pulse_req();
            repeat (5) @(posedge clk);
        end
        wait_frames(2, 8 * NPIX);
        repeat (30) @(negedge clk);
        chk("pend_idle", 64'(busy), 0);
        chk("pend_frames", 64'(frames), 64'(base + 2));
        chk("pend_queue_empty", 64'(exp_q.size()), 0);

        // Auto refresh: back-to-back frames with one IDLE cycle between.
        rdy_rand = 1'b0;
        board = rand_board();
        exp_q.push_back(board);
        exp_q.push_back(board);
        @(posedge clk); #2 auto_refresh = 1'b1;
        wait_frames(1, NPIX + 20);
        d1 = done_cyc;
        wait_frames(1, NPIX + 20);
        auto_refresh = 1'b0;
        chk("auto_gap", 64'(first_we_cyc - d1), 3);
        repeat (10) @(negedge clk);
        chk("auto_stop", 64'(busy), 0);

        // Reset at pixel 1000 aborts silently.
        rdy_rand = 1'b1;
        base = frames;
        board = rand_board();
        exp_q.push_back(board);
        pulse_req();
        for (int i = 0; i < 4 * NPIX && px_cnt < 1000; i++) @(negedge clk);
        chk("reach_px1000", 64'(px_cnt >= 1000), 1);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("abort_we", 64'(fb_we), 0);
        chk("abort_busy", 64'(busy), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(frames), 64'(base));

        // Recovery frame after the abort.
        board = rand_board();
        exp_q.push_back(board);
        pulse_req();
        wait_frames(1, 4 * NPIX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
